mac_bank: RTL and testbench



---
 rtl/mac_pkg.sv | 51 +++++
 rtl/mac_lane.sv | 91 +++++++++
 rtl/mac_bank.sv | 128 ++++++++++++
 tb/tb_mac_bank.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and arithmetic helpers for the mac_bank datapath.
//   - lane_ctrl_t : per-beat control bundle broadcast from mac_bank to every lane
//   - max_of/min_of, ovf_detect, sat_wrap : width-parametrised range helpers,
//     evaluated on a 64-bit signed carrier so any ACC_WIDTH up to 63 fits
//   - lane_lsb    : bit offset of lane k inside a packed multi-lane bus
package mac_pkg;

    localparam int ACC_W_MAX = 64;

    typedef logic signed [ACC_W_MAX-1:0] wide_t;

    typedef struct packed {
        logic en;    // pipeline advance
        logic load;  // accepted input beat: capture product
        logic v1;    // stage-1 holds a beat
        logic last;  // stage-1 beat closes the frame
        logic clr;   // frame abort
    } lane_ctrl_t;

    function automatic wide_t max_of(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t min_of(input int w);
        return -max_of(w) - wide_t'(1);
    endfunction

    // True when s does not fit a w-bit signed value.
    function automatic logic ovf_detect(input wide_t s, input int w);
        return (s > max_of(w)) || (s < min_of(w));
    endfunction

    // Clamp to the w-bit range (sat=1) or keep the low w bits, sign-extended (sat=0).
    function automatic wide_t sat_wrap(input wide_t s, input int w, input logic sat);
        wide_t r;
        if (sat && (s > max_of(w))) begin
            r = max_of(w);
        end else if (sat && (s < min_of(w))) begin
            r = min_of(w);
        end else begin
            r = s <<< (ACC_W_MAX - w);
            r = r >>> (ACC_W_MAX - w);
        end
        return r;
    endfunction

    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one multiply-accumulate lane of mac_bank.
//   clk_i/rst_ni : clock, async active-low reset
//   ctrl_i       : en/load/v1/last/clr from the shared controller
//   a_i, b_i     : signed operands of the current input beat
//   res_o        : frame result register
//   ovf_o        : overflow flag belonging to res_o
// Stage 1 registers the full-width product; stage 2 folds it into the
// accumulator with the saturate/wrap rule applied at every beat.
module mac_lane
    import mac_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  lane_ctrl_t                  ctrl_i,
    input  logic signed [IN_WIDTH-1:0]  a_i,
    input  logic signed [IN_WIDTH-1:0]  b_i,
    output logic signed [ACC_WIDTH-1:0] res_o,
    output logic                        ovf_o
);

    localparam int PW = 2 * IN_WIDTH;

    logic signed [PW-1:0]        prod_q, prod_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] res_q, res_d;
    logic                        stk_q, stk_d;
    logic                        ovf_q, ovf_d;

    logic signed [ACC_WIDTH:0]   sum;
    logic signed [ACC_WIDTH-1:0] resolved;
    logic                        beat_ovf;
    logic                        step;

    // One extra bit is enough: |product| never exceeds the accumulator range.
    assign sum      = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_q);
    assign beat_ovf = ovf_detect(wide_t'(sum), ACC_WIDTH);
    assign resolved = ACC_WIDTH'(sat_wrap(wide_t'(sum), ACC_WIDTH, SATURATE));
    assign step     = ctrl_i.en && ctrl_i.v1 && !ctrl_i.clr;

    always_comb begin
        prod_d = prod_q;
        acc_d  = acc_q;
        stk_d  = stk_q;
        res_d  = res_q;
        ovf_d  = ovf_q;

        if (ctrl_i.load) begin
            prod_d = PW'(a_i) * PW'(b_i);
        end

        if (ctrl_i.clr) begin
            acc_d = '0;
            stk_d = 1'b0;
        end else if (step) begin
            if (ctrl_i.last) begin
                // Frame closes: publish and restart with no bubble.
                res_d = resolved;
                ovf_d = stk_q | beat_ovf;
                acc_d = '0;
                stk_d = 1'b0;
            end else begin
                acc_d = resolved;
                stk_d = stk_q | beat_ovf;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q <= '0;
            acc_q  <= '0;
            stk_q  <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            stk_q  <= stk_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
        end
    end

    assign res_o = res_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_bank.sv
// mac_bank: NUM_CH-lane pipelined multiply-accumulate bank.
//   Clk_CI, Rst_RBI         : clock, async active-low reset
//   Clr_SI                  : synchronous frame abort (output register untouched)
//   InValid_SI/InReady_SO   : shared input beat handshake
//   In0_DI, In1_DI          : packed signed operands, lane k at [k*IN_WIDTH +: IN_WIDTH]
//   OutValid_SO/OutReady_SI : frame result handshake
//   Out_DO                  : packed signed results, lane k at [k*ACC_WIDTH +: ACC_WIDTH]
//   Ovf_SO                  : per-lane overflow flag of the presented frame
// Holds the beat counter, stage-1 valid/last and the result-valid flag; the
// datapath lives in mac_lane. The whole pipeline stalls while a result is
// held and not taken.
module mac_bank
    import mac_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter int NUM_CH    = 4,
    parameter int ACC_LEN   = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RBI,
    input  logic                          Clr_SI,
    input  logic                          InValid_SI,
    output logic                          InReady_SO,
    input  logic [NUM_CH*IN_WIDTH-1:0]    In0_DI,
    input  logic [NUM_CH*IN_WIDTH-1:0]    In1_DI,
    output logic                          OutValid_SO,
    input  logic                          OutReady_SI,
    output logic [NUM_CH*ACC_WIDTH-1:0]   Out_DO,
    output logic [NUM_CH-1:0]             Ovf_SO
);

    localparam int               CNT_W    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    if (ACC_WIDTH < 2 * IN_WIDTH) begin : g_bad_acc_width
        $error("mac_bank: ACC_WIDTH must be >= 2*IN_WIDTH");
    end
    if (ACC_LEN < 1) begin : g_bad_acc_len
        $error("mac_bank: ACC_LEN must be >= 1");
    end

    logic             en, fire, land;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             v1_q, v1_d;
    logic             last_q, last_d;
    logic             ov_q, ov_d;
    lane_ctrl_t       ctrl;

    logic [NUM_CH-1:0][ACC_WIDTH-1:0] res;
    logic [NUM_CH-1:0]                ovf;

    assign en   = !(ov_q && !OutReady_SI);
    // A beat offered during Clr_SI is dropped even though InReady_SO is high.
    assign fire = InValid_SI && en && !Clr_SI;
    assign land = en && v1_q && last_q && !Clr_SI;

    always_comb begin
        cnt_d  = cnt_q;
        v1_d   = v1_q;
        last_d = last_q;
        ov_d   = ov_q;

        if (Clr_SI) begin
            cnt_d = '0;
            v1_d  = 1'b0;
        end else if (en) begin
            v1_d   = fire;
            last_d = fire && (cnt_q == CNT_LAST);
            if (fire) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
        end

        // A landing result overrides retirement so back-to-back frames keep valid high.
        if (land) begin
            ov_d = 1'b1;
        end else if (ov_q && OutReady_SI) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            cnt_q  <= '0;
            v1_q   <= 1'b0;
            last_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            v1_q   <= v1_d;
            last_q <= last_d;
            ov_q   <= ov_d;
        end
    end

    always_comb begin
        ctrl      = '0;
        ctrl.en   = en;
        ctrl.load = fire;
        ctrl.v1   = v1_q;
        ctrl.last = last_q;
        ctrl.clr  = Clr_SI;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        mac_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .SATURATE  (SATURATE)
        ) u_lane (
            .clk_i  (Clk_CI),
            .rst_ni (Rst_RBI),
            .ctrl_i (ctrl),
            .a_i    (In0_DI[lane_lsb(k, IN_WIDTH) +: IN_WIDTH]),
            .b_i    (In1_DI[lane_lsb(k, IN_WIDTH) +: IN_WIDTH]),
            .res_o  (res[k]),
            .ovf_o  (ovf[k])
        );
    end

    assign InReady_SO  = en;
    assign OutValid_SO = ov_q;
    assign Out_DO      = res;
    assign Ovf_SO      = ovf;

endmodule

// File: tb/tb_mac_bank.sv
// tb_mac_bank: three mac_bank instances (24-bit saturating, 16-bit saturating,
// 16-bit wrapping; all 4 lanes, ACC_LEN=4) share one stimulus stream. A
// frame-level reference model is compared against every output each cycle,
// and directed frames pin hand-computed results.
module tb_mac_bank;

    localparam int NCH = 4;
    localparam int IW  = 8;
    localparam int AL  = 4;

    typedef logic [NCH-1:0][IW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic in_vld = 1'b0;
    logic out_rdy = 1'b1;
    vec_t a_v = '0;
    vec_t b_v = '0;

    logic rdyA, rdyB, rdyC, ovA, ovB, ovC;
    logic [NCH*24-1:0] outA;
    logic [NCH*16-1:0] outB, outC;
    logic [NCH-1:0] ovfA, ovfB, ovfC;

    always #5 clk = ~clk;

    mac_bank #(.IN_WIDTH(IW), .ACC_WIDTH(24), .NUM_CH(NCH), .ACC_LEN(AL), .SATURATE(1'b1)) u_a (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Clr_SI(clr), .InValid_SI(in_vld), .InReady_SO(rdyA),
        .In0_DI(a_v), .In1_DI(b_v), .OutValid_SO(ovA), .OutReady_SI(out_rdy), .Out_DO(outA), .Ovf_SO(ovfA));
    mac_bank #(.IN_WIDTH(IW), .ACC_WIDTH(16), .NUM_CH(NCH), .ACC_LEN(AL), .SATURATE(1'b1)) u_b (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Clr_SI(clr), .InValid_SI(in_vld), .InReady_SO(rdyB),
        .In0_DI(a_v), .In1_DI(b_v), .OutValid_SO(ovB), .OutReady_SI(out_rdy), .Out_DO(outB), .Ovf_SO(ovfB));
    mac_bank #(.IN_WIDTH(IW), .ACC_WIDTH(16), .NUM_CH(NCH), .ACC_LEN(AL), .SATURATE(1'b0)) u_c (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Clr_SI(clr), .InValid_SI(in_vld), .InReady_SO(rdyC),
        .In0_DI(a_v), .In1_DI(b_v), .OutValid_SO(ovC), .OutReady_SI(out_rdy), .Out_DO(outC), .Ovf_SO(ovfC));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int d, input int c, input logic signed [63:0] got, input longint exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d lane%0d: got %0d expected %0d", nm, d, c, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int     accw [3] = '{24, 16, 16};
    bit     satm [3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc  [3][NCH];
    longint m_land [3][NCH];
    longint m_out  [3][NCH];
    bit     m_stk  [3][NCH];
    bit     m_lovf [3][NCH];
    bit     m_ovf  [3][NCH];
    bit     m_ov, m_lv, m_en, m_acc_evt;
    int     m_bc;

    function automatic void resolve(input longint s, input int w, input bit sat, output longint r, output bit o);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        o  = (s > hi) || (s < lo);
        if (!o)       r = s;
        else if (sat) r = (s > hi) ? hi : lo;
        else          r = (s > hi) ? s - (longint'(1) << w) : s + (longint'(1) << w);
    endfunction

    // A frame's result is known the moment its last beat is accepted; it
    // reaches the output register at the next advancing edge unless aborted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ov = 0; m_lv = 0; m_bc = 0; m_acc_evt = 0;
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < NCH; c++) begin
                    m_acc[d][c] = 0; m_land[d][c] = 0; m_out[d][c] = 0;
                    m_stk[d][c] = 0; m_lovf[d][c] = 0; m_ovf[d][c] = 0;
                end
        end else begin
            m_en = !(m_ov && !out_rdy);
            m_acc_evt = 0;
            if (m_en) begin
                if (m_lv && !clr) begin
                    for (int d = 0; d < 3; d++)
                        for (int c = 0; c < NCH; c++) begin
                            m_out[d][c] = m_land[d][c];
                            m_ovf[d][c] = m_lovf[d][c];
                        end
                    m_ov = 1;
                end else if (m_ov && out_rdy) begin
                    m_ov = 0;
                end
                m_lv = 0;
            end
            if (clr) begin
                m_lv = 0; m_bc = 0;
                for (int d = 0; d < 3; d++)
                    for (int c = 0; c < NCH; c++) begin
                        m_acc[d][c] = 0; m_stk[d][c] = 0;
                    end
            end else if (m_en && in_vld) begin
                m_acc_evt = 1;
                for (int d = 0; d < 3; d++)
                    for (int c = 0; c < NCH; c++) begin
                        longint r;
                        bit o;
                        resolve(m_acc[d][c] + longint'($signed(a_v[c])) * longint'($signed(b_v[c])),
                                accw[d], satm[d], r, o);
                        if (m_bc == AL - 1) begin
                            m_land[d][c] = r; m_lovf[d][c] = m_stk[d][c] | o;
                            m_acc[d][c] = 0;  m_stk[d][c] = 0;
                        end else begin
                            m_acc[d][c] = r;  m_stk[d][c] = m_stk[d][c] | o;
                        end
                    end
                if (m_bc == AL - 1) begin m_lv = 1; m_bc = 0; end
                else m_bc++;
            end
        end
    end

    task automatic check_all();
        longint er;
        er = (m_ov && !out_rdy) ? 0 : 1;
        chk("out_valid", 0, 0, ovA, m_ov);
        chk("out_valid", 1, 0, ovB, m_ov);
        chk("out_valid", 2, 0, ovC, m_ov);
        chk("in_ready", 0, 0, rdyA, er);
        chk("in_ready", 1, 0, rdyB, er);
        chk("in_ready", 2, 0, rdyC, er);
        for (int c = 0; c < NCH; c++) begin
            chk("out", 0, c, $signed(outA[c*24 +: 24]), m_out[0][c]);
            chk("out", 1, c, $signed(outB[c*16 +: 16]), m_out[1][c]);
            chk("out", 2, c, $signed(outC[c*16 +: 16]), m_out[2][c]);
            chk("ovf", 0, c, ovfA[c], m_ovf[0][c]);
            chk("ovf", 1, c, ovfB[c], m_ovf[1][c]);
            chk("ovf", 2, c, ovfC[c], m_ovf[2][c]);
        end
    endtask

    always @(negedge clk) check_all();

    // ---------------- stimulus helpers ----------------
    function automatic vec_t mk(input int l0, input int l1);
        vec_t v;
        v = '0;
        v[0] = IW'(l0);
        v[1] = IW'(l1);
        return v;
    endfunction

    function automatic logic [IW-1:0] pick();
        case ($urandom % 4)
            0:       return 8'h80;
            1:       return 8'h7f;
            default: return IW'($urandom);
        endcase
    endfunction

    task automatic send(input vec_t av, input vec_t bv);
        a_v = av; b_v = bv; in_vld = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_acc_evt) break;
            if (i == 49) begin
                nvec++; nerr++;
                $display("FAIL send_timeout dut0 lane0: got no acceptance expected acceptance");
            end
        end
        in_vld = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ovA) return;
        end
        nvec++; nerr++;
        $display("FAIL wait_valid_timeout dut0 lane0: got 0 expected 1");
    endtask

    // Four identical beats, then pin latency and a single-cycle valid pulse on dut0.
    task automatic frame_a(input int a0, input int b0, input int a1, input int b1, input longint e0, input longint e1);
        repeat (AL) send(mk(a0, a1), mk(b0, b1));
        @(negedge clk); chk("lat_pre", 0, 0, ovA, 0);
        @(negedge clk); chk("lat_valid", 0, 0, ovA, 1);
        chk("res", 0, 0, $signed(outA[23:0]), e0);
        chk("res", 0, 1, $signed(outA[47:24]), e1);
        chk("res_ovf", 0, 0, ovfA[0], 0);
        chk("res_ovf", 0, 1, ovfA[1], 0);
        @(negedge clk); chk("one_cycle", 0, 0, ovA, 0);
    endtask

    initial begin
        // reset
        @(negedge clk);
        chk("rst_out", 0, 0, $signed(outA[23:0]), 0);
        chk("rst_ovf", 0, 0, ovfA, 0);
        chk("rst_valid", 0, 0, ovA, 0);
        chk("rst_ready", 0, 0, rdyA, 1);
        #2 rst_n = 1'b1;

        frame_a(3, 5, -2, 7, 60, -56);
        frame_a(-128, -128, -128, 127, 65536, -65024);

        // backpressure while a second frame streams
        repeat (AL) send(mk(2, 0), mk(3, 0));
        out_rdy = 1'b0;
        fork
            repeat (AL) send(mk(-1, 0), mk(4, 0));
            begin
                @(negedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_ready", 0, 0, rdyA, 0);
                    chk("bp_hold", 0, 0, $signed(outA[23:0]), 24);
                end
                @(posedge clk); #1 out_rdy = 1'b1;
            end
        join
        wait_valid();
        chk("bp_second", 0, 0, $signed(outA[23:0]), -16);

        // saturation vs wrap, then a clean frame clears the flag
        repeat (AL) send(mk(127, 0), mk(127, 0));
        @(negedge clk); @(negedge clk);
        chk("sat_res", 1, 0, $signed(outB[15:0]), 32767);
        chk("sat_ovf", 1, 0, ovfB[0], 1);
        chk("wrap_res", 2, 0, $signed(outC[15:0]), -1020);
        chk("wrap_ovf", 2, 0, ovfC[0], 1);
        chk("wide_res", 0, 0, $signed(outA[23:0]), 64516);
        repeat (AL) send(mk(1, 0), mk(1, 0));
        @(negedge clk); @(negedge clk);
        chk("clean_ovf", 1, 0, ovfB[0], 0);
        chk("clean_ovf", 2, 0, ovfC[0], 0);

        // abort while a result is held
        repeat (AL) send(mk(5, 0), mk(5, 0));
        out_rdy = 1'b0;
        wait_valid();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_pend_valid", 0, 0, ovA, 1);
        chk("clr_pend_res", 0, 0, $signed(outA[23:0]), 100);
        @(posedge clk); #1 out_rdy = 1'b1;

        // abort mid-frame
        repeat (2) send(mk(9, 0), mk(9, 0));
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        repeat (AL) send(mk(1, 0), mk(1, 0));
        wait_valid();
        chk("clr_res", 0, 0, $signed(outA[23:0]), 4);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NCH; c++) begin
                a_v[c] = pick();
                b_v[c] = pick();
            end
            in_vld  = ($urandom % 4) != 0;
            out_rdy = ($urandom % 4) != 0;
            clr     = ($urandom % 40) == 0;
            @(posedge clk); #1;
        end
        in_vld = 1'b0; clr = 1'b0; out_rdy = 1'b1;

        // async reset in the middle of a frame
        @(posedge clk); #1;
        send(mk(7, 0), mk(7, 0));
        send(mk(7, 0), mk(7, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 0, 0, ovA, 0);
        chk("mid_rst_ready", 0, 0, rdyA, 1);
        chk("mid_rst_out", 0, 0, $signed(outA[23:0]), 0);
        chk("mid_rst_ovf", 0, 0, ovfA, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (AL) send(mk(1, 0), mk(2, 0));
        wait_valid();
        chk("post_rst_res", 0, 0, $signed(outA[23:0]), 8);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
